// File: rtl/fifo_arb_pkg.sv
// Shared constants and types for the FIFO write-port arbiter.
// Credit width covers 0..DEPTH inclusive.
package fifo_arb_pkg;
    localparam int NREQ_DEF  = 4;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 8;
    localparam int CW        = $clog2(DEPTH_DEF + 1);

    typedef logic [CW-1:0] credit_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of elig searching from last+1 upward, wrapping.
// Purely combinational, no backpressure of its own.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] onehot,
    output logic [LW-1:0]   idx,
    output logic            any
);
    int pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        for (int off = 1; off <= NREQ; off++) begin
            pos = (int'(last) + off) % NREQ;
            if (!any && elig[pos]) begin
                any         = 1'b1;
                onehot[pos] = 1'b1;
                idx         = LW'(pos);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin share of one FIFO write port; registered we/din one cycle after the grant.
// Grants stall while no credit is left; credit returns one per rd_pop pulse.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CRW  = $clog2(DEPTH + 1),
    localparam int LW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    input  logic [NREQ-1:0]    en,
    output logic [NREQ-1:0]    gnt,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_din,
    input  logic               rd_pop,
    output logic [CRW-1:0]     credit,
    output logic               no_credit,
    output logic               err
);
    logic [LW-1:0]   last;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] pick_onehot;
    logic [LW-1:0]   pick_idx;
    logic            pick_any;
    logic [DW-1:0]   sel_dat;

    assign elig = req & en & {NREQ{credit != '0}};

    rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
        .elig   (elig),
        .last   (last),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Mask during reset so gnt reads zero the instant rst falls.
    assign gnt       = rst ? pick_onehot : '0;
    assign no_credit = (credit == '0);

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) sel_dat = sel_dat | din[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last     <= LW'(NREQ - 1);
            credit   <= CRW'(DEPTH);
            fifo_we  <= 1'b0;
            fifo_din <= '0;
            err      <= 1'b0;
        end else begin
            fifo_we <= pick_any;
            if (pick_any) begin
                last     <= pick_idx;
                fifo_din <= sel_dat;
            end
            // Grant and pop together cancel; a pop at full credit is a consumer bug.
            case ({pick_any, rd_pop})
                2'b10:   credit <= credit - CRW'(1);
                2'b01:   if (credit != CRW'(DEPTH)) credit <= credit + CRW'(1);
                default: ;
            endcase
            if (rd_pop && credit == CRW'(DEPTH)) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a queue-free behavioural model,
// with directed scenarios whose expectations are written as literals.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    en;
    logic [NREQ-1:0]    gnt;
    logic               fifo_we;
    logic [DW-1:0]      fifo_din;
    logic               rd_pop;
    credit_t            credit;
    logic               no_credit;
    logic               err;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .en        (en),
        .gnt       (gnt),
        .fifo_we   (fifo_we),
        .fifo_din  (fifo_din),
        .rd_pop    (rd_pop),
        .credit    (credit),
        .no_credit (no_credit),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit run_chk = 1'b0;

    // Behavioural model state
    int m_credit = DEPTH;
    int m_last   = NREQ - 1;
    bit m_err    = 1'b0;
    bit m_we     = 1'b0;
    int m_din    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner under round-robin from last+1, or -1 if nobody may write.
    function automatic int model_pick();
        if (m_credit == 0) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (req[i] && en[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_credit = DEPTH;
            m_last   = NREQ - 1;
            m_err    = 1'b0;
            m_we     = 1'b0;
            m_din    = 0;
        end else begin
            int w;
            w = model_pick();
            if (rd_pop && m_credit == DEPTH) m_err = 1'b1;
            if (w >= 0) begin
                m_last = w;
                m_we   = 1'b1;
                m_din  = int'(din[w*DW +: DW]);
                if (!rd_pop) m_credit = m_credit - 1;
            end else begin
                m_we = 1'b0;
                if (rd_pop && m_credit < DEPTH) m_credit = m_credit + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk && rst) begin
            int w;
            logic [NREQ-1:0] eg;
            w  = model_pick();
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            check("m_gnt", 32'(gnt), 32'(eg));
            check("m_we", 32'(fifo_we), 32'(m_we));
            check("m_din", 32'(fifo_din), 32'(m_din));
            check("m_credit", 32'(credit), 32'(m_credit));
            check("m_no_credit", 32'(no_credit), 32'(m_credit == 0));
            check("m_err", 32'(err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; req = '0; en = '0; din = '0; rd_pop = 1'b0;
        #13;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_we", 32'(fifo_we), 32'h0);
        check("rst_credit", 32'(credit), 32'd8);
        check("rst_no_credit", 32'(no_credit), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        #10 rst = 1'b1;
        run_chk = 1'b1;
        tick();

        // Fairness rotation with data following one cycle later
        req = 4'b1111; en = 4'b1111; din = 32'h40302010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rot_gnt", 32'(gnt), 32'(1 << i));
            if (i > 0) begin
                check("rot_we", 32'(fifo_we), 32'h1);
                check("rot_din", 32'(fifo_din), 32'(8'h10 * i));
            end
            tick();
        end
        req = '0;
        @(negedge clk);
        check("rot_din_last", 32'(fifo_din), 32'h40);
        check("rot_credit", 32'(credit), 32'd4);

        // Exhaust credit, then a single returned credit yields exactly one grant
        rd_pop = 1'b1;
        repeat (4) tick();
        rd_pop = 1'b0; req = 4'b0001; din = 32'h000000A5;
        repeat (10) tick();
        @(negedge clk);
        check("ex_credit", 32'(credit), 32'd0);
        check("ex_no_credit", 32'(no_credit), 32'h1);
        check("ex_gnt", 32'(gnt), 32'h0);
        tick();
        rd_pop = 1'b1;
        @(negedge clk);
        check("pop0_gnt", 32'(gnt), 32'h0);
        tick();
        rd_pop = 1'b0;
        @(negedge clk);
        check("pop0_credit", 32'(credit), 32'd1);
        check("pop0_regnt", 32'(gnt), 32'h1);
        tick();
        @(negedge clk);
        check("pop0_empty", 32'(credit), 32'd0);
        check("pop0_gnt_off", 32'(gnt), 32'h0);

        // Grant and pop in the same cycle leave credit unchanged
        req = '0; rd_pop = 1'b1;
        repeat (3) tick();
        req = 4'b0001;
        tick();
        req = '0; rd_pop = 1'b0;
        @(negedge clk);
        check("both_credit", 32'(credit), 32'd3);

        // Enable mask blocks requester 2 without moving the pointer
        req = 4'b0101; en = 4'b0001; rd_pop = 1'b1;
        @(negedge clk);
        check("mask_gnt0", 32'(gnt), 32'h1);
        tick();
        @(negedge clk);
        check("mask_gnt1", 32'(gnt), 32'h1);
        tick();
        en = 4'b1111; rd_pop = 1'b0;
        @(negedge clk);
        check("mask_gnt2", 32'(gnt), 32'h4);
        tick();
        req = '0;

        // Spurious pop at full credit sets sticky err
        while (m_credit < DEPTH) begin
            rd_pop = 1'b1;
            tick();
        end
        rd_pop = 1'b0;
        @(negedge clk);
        check("err_pre", 32'(err), 32'h0);
        tick();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        @(negedge clk);
        check("err_credit", 32'(credit), 32'd8);
        check("err_set", 32'(err), 32'h1);
        repeat (3) tick();
        @(negedge clk);
        check("err_sticky", 32'(err), 32'h1);

        // Asynchronous reset mid-cycle with writes in flight
        tick();
        req = 4'b0001;
        repeat (3) tick();
        check("pre_rst_credit", 32'(credit), 32'd5);
        check("pre_rst_we", 32'(fifo_we), 32'h1);
        req = 4'b1111;
        #1 rst = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'h0);
        check("arst_we", 32'(fifo_we), 32'h0);
        check("arst_din", 32'(fifo_din), 32'h0);
        check("arst_credit", 32'(credit), 32'd8);
        check("arst_no_credit", 32'(no_credit), 32'h0);
        check("arst_err", 32'(err), 32'h0);
        req = 4'b1010;
        rst = 1'b1;
        @(negedge clk);
        check("arst_first", 32'(gnt), 32'h2);
        tick();

        // Random traffic, occasional mid-cycle reset
        for (int c = 0; c < 3000; c++) begin
            req    = NREQ'($urandom);
            en     = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '1;
            din    = $urandom;
            rd_pop = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
            end
            tick();
        end
        run_chk = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
